// File: rtl/rob_commit_unit_pkg.sv
// Shared constants and types for the reorder buffer: index width, depth,
// instruction class encodings and the per-entry bookkeeping record.
package rob_commit_unit_pkg;

    localparam int ROB_BIT  = 3;
    localparam int ROB_SIZE = 2 ** ROB_BIT;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_BRANCH = 2'd1,
        ROB_TYPE_STORE  = 2'd2
    } rob_type_e;

    // Ready bits and values live in packed vectors so the lookup ports can see them.
    typedef struct packed {
        rob_type_e   rob_type;
        logic [4:0]  rd;
        logic        pred_jump;
        logic        jump;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit_lookup_port.sv
// One dependency lookup port: entry ready/value with a same-cycle bypass of
// the CDB broadcast.
module rob_lookup_port
    import rob_commit_unit_pkg::*;
(
    input  logic [ROB_BIT-1:0]         get_rob_entry,
    input  logic [ROB_SIZE-1:0]        ready_vec,
    input  logic [ROB_SIZE-1:0][31:0]  value_vec,
    input  logic                       wb_valid,
    input  logic [ROB_BIT-1:0]         wb_rob_entry,
    input  logic [31:0]                wb_value,
    output logic                       ready,
    output logic [31:0]                value
);

    logic hit_s;

    assign hit_s = wb_valid && (wb_rob_entry == get_rob_entry);

    // Broadcast result wins over stored value so consumers see it in the producing cycle.
    always_comb begin
        ready = ready_vec[get_rob_entry] | hit_s;
        if (hit_s) begin
            value = wb_value;
        end else begin
            value = value_vec[get_rob_entry];
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation at the tail, CDB result capture, in-order
// retirement from the head, and a full flush on a mispredicted branch.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic               issue_pred_jump,
    output logic [ROB_BIT-1:0] issue_rob_entry,
    output logic               rob_full,
    input  logic               wb_valid,
    input  logic [ROB_BIT-1:0] wb_rob_entry,
    input  logic [31:0]        wb_value,
    input  logic               wb_jump,
    input  logic [31:0]        wb_target,
    input  logic [ROB_BIT-1:0] get_rob_entry1,
    output logic               ready1,
    output logic [31:0]        value1,
    input  logic [ROB_BIT-1:0] get_rob_entry2,
    output logic               ready2,
    output logic [31:0]        value2,
    output logic               rob_commit,
    output logic [4:0]         commit_reg_id,
    output logic [31:0]        commit_reg_data,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               store_commit,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc
);

    localparam logic [ROB_BIT:0]   COUNT_FULL = (ROB_BIT + 1)'(ROB_SIZE);
    localparam logic [ROB_BIT:0]   COUNT_ONE  = (ROB_BIT + 1)'(1'b1);
    localparam logic [ROB_BIT-1:0] IDX_ONE    = ROB_BIT'(1'b1);

    logic [ROB_BIT-1:0]        head_r;
    logic [ROB_BIT-1:0]        tail_r;
    logic [ROB_BIT:0]          count_r;
    logic [ROB_BIT:0]          count_next_s;
    logic [ROB_SIZE-1:0]       busy_r;
    logic [ROB_SIZE-1:0]       ready_r;
    logic [ROB_SIZE-1:0][31:0] value_r;
    rob_entry_t                entry_r [ROB_SIZE];

    logic                      rob_commit_r;
    logic [4:0]                commit_reg_id_r;
    logic [31:0]               commit_reg_data_r;
    logic [ROB_BIT-1:0]        commit_rob_entry_r;
    logic                      store_commit_r;
    logic                      rob_clear_up_r;
    logic [31:0]               clear_pc_r;

    rob_entry_t                head_entry_s;
    logic                      head_ready_s;
    logic                      commit_s;
    logic                      mispredict_s;
    logic                      issue_s;
    logic                      wb_s;

    assign issue_rob_entry  = tail_r;
    assign rob_full         = (count_r == COUNT_FULL);
    assign rob_commit       = rob_commit_r;
    assign commit_reg_id    = commit_reg_id_r;
    assign commit_reg_data  = commit_reg_data_r;
    assign commit_rob_entry = commit_rob_entry_r;
    assign store_commit     = store_commit_r;
    assign rob_clear_up     = rob_clear_up_r;
    assign clear_pc         = clear_pc_r;

    // Per-cycle retire, flush, allocate and capture decisions.
    always_comb begin
        head_entry_s = entry_r[head_r];
        head_ready_s = (count_r != {(ROB_BIT + 1){1'b0}}) && ready_r[head_r];
        commit_s     = 1'b0;
        mispredict_s = 1'b0;
        if (head_ready_s) begin
            if ((head_entry_s.rob_type == ROB_TYPE_BRANCH) &&
                (head_entry_s.jump != head_entry_s.pred_jump)) begin
                mispredict_s = 1'b1;
            end else begin
                commit_s = 1'b1;
            end
        end else begin
            commit_s = 1'b0;
        end
        // The cycle showing rob_clear_up belongs to the squashed path.
        issue_s = issue_valid && !rob_full && !rob_clear_up_r;
        wb_s    = wb_valid && busy_r[wb_rob_entry] && !rob_clear_up_r &&
                  !(head_ready_s && (wb_rob_entry == head_r));
        if (issue_s && !commit_s) begin
            count_next_s = count_r + COUNT_ONE;
        end else if (!issue_s && commit_s) begin
            count_next_s = count_r - COUNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Entry storage, pointers and registered retirement outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r             <= {ROB_BIT{1'b0}};
            tail_r             <= {ROB_BIT{1'b0}};
            count_r            <= {(ROB_BIT + 1){1'b0}};
            busy_r             <= {ROB_SIZE{1'b0}};
            ready_r            <= {ROB_SIZE{1'b0}};
            value_r            <= {(ROB_SIZE * 32){1'b0}};
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_r[i] <= {$bits(rob_entry_t){1'b0}};
            end
            rob_commit_r       <= 1'b0;
            commit_reg_id_r    <= 5'd0;
            commit_reg_data_r  <= 32'd0;
            commit_rob_entry_r <= {ROB_BIT{1'b0}};
            store_commit_r     <= 1'b0;
            rob_clear_up_r     <= 1'b0;
            clear_pc_r         <= 32'd0;
        end else if (rdy_in) begin
            rob_commit_r   <= commit_s | mispredict_s;
            store_commit_r <= commit_s && (head_entry_s.rob_type == ROB_TYPE_STORE);
            rob_clear_up_r <= mispredict_s;
            if (commit_s || mispredict_s) begin
                commit_rob_entry_r <= head_r;
                commit_reg_data_r  <= value_r[head_r];
                commit_reg_id_r    <= (commit_s && (head_entry_s.rob_type == ROB_TYPE_REG)) ?
                                      head_entry_s.rd : 5'd0;
            end
            if (mispredict_s) begin
                clear_pc_r <= head_entry_s.target;
                head_r     <= {ROB_BIT{1'b0}};
                tail_r     <= {ROB_BIT{1'b0}};
                count_r    <= {(ROB_BIT + 1){1'b0}};
                busy_r     <= {ROB_SIZE{1'b0}};
                ready_r    <= {ROB_SIZE{1'b0}};
            end else begin
                if (commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + IDX_ONE;
                end
                if (issue_s) begin
                    busy_r[tail_r]  <= 1'b1;
                    ready_r[tail_r] <= 1'b0;
                    entry_r[tail_r] <= '{rob_type:  rob_type_e'(issue_type),
                                         rd:        issue_rd,
                                         pred_jump: issue_pred_jump,
                                         jump:      1'b0,
                                         target:    32'd0};
                    tail_r          <= tail_r + IDX_ONE;
                end
                if (wb_s) begin
                    ready_r[wb_rob_entry]        <= 1'b1;
                    value_r[wb_rob_entry]        <= wb_value;
                    entry_r[wb_rob_entry].jump   <= wb_jump;
                    entry_r[wb_rob_entry].target <= wb_target;
                end
                count_r <= count_next_s;
            end
        end
    end

    rob_lookup_port u_lookup1 (
        .get_rob_entry (get_rob_entry1),
        .ready_vec     (ready_r),
        .value_vec     (value_r),
        .wb_valid      (wb_valid),
        .wb_rob_entry  (wb_rob_entry),
        .wb_value      (wb_value),
        .ready         (ready1),
        .value         (value1)
    );

    rob_lookup_port u_lookup2 (
        .get_rob_entry (get_rob_entry2),
        .ready_vec     (ready_r),
        .value_vec     (value_r),
        .wb_valid      (wb_valid),
        .wb_rob_entry  (wb_rob_entry),
        .wb_value      (wb_value),
        .ready         (ready2),
        .value         (value2)
    );

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               rdy_in = 1'b1;
    logic               issue_valid = 1'b0;
    logic [1:0]         issue_type = 2'd0;
    logic [4:0]         issue_rd = 5'd0;
    logic               issue_pred_jump = 1'b0;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_full;
    logic               wb_valid = 1'b0;
    logic [ROB_BIT-1:0] wb_rob_entry = '0;
    logic [31:0]        wb_value = 32'd0;
    logic               wb_jump = 1'b0;
    logic [31:0]        wb_target = 32'd0;
    logic [ROB_BIT-1:0] get_rob_entry1 = '0;
    logic               ready1;
    logic [31:0]        value1;
    logic [ROB_BIT-1:0] get_rob_entry2 = '0;
    logic               ready2;
    logic [31:0]        value2;
    logic               rob_commit;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               store_commit;
    logic               rob_clear_up;
    logic [31:0]        clear_pc;

    always #5 clk_in = ~clk_in;

    rob_commit_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_jump(issue_pred_jump), .issue_rob_entry(issue_rob_entry), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_entry(wb_rob_entry), .wb_value(wb_value),
        .wb_jump(wb_jump), .wb_target(wb_target),
        .get_rob_entry1(get_rob_entry1), .ready1(ready1), .value1(value1),
        .get_rob_entry2(get_rob_entry2), .ready2(ready2), .value2(value2),
        .rob_commit(rob_commit), .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
        .commit_rob_entry(commit_rob_entry), .store_commit(store_commit),
        .rob_clear_up(rob_clear_up), .clear_pc(clear_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the in-flight window is a queue, oldest at the front.
    typedef struct {
        logic [ROB_BIT-1:0] idx;
        int                 typ;
        logic [4:0]         rd;
        bit                 pred;
        bit                 rdy;
        logic [31:0]        val;
        bit                 jmp;
        logic [31:0]        tgt;
    } ent_t;

    ent_t               mq[$];
    logic [ROB_BIT-1:0] m_tail;
    bit                 m_clr;
    logic               exp_commit, exp_store, exp_clear;
    logic [4:0]         exp_id;
    logic [31:0]        exp_data, exp_pc;
    logic [ROB_BIT-1:0] exp_entry;

    function automatic bit m_ready(input logic [ROB_BIT-1:0] g);
        if (wb_valid && wb_rob_entry == g) return 1'b1;
        foreach (mq[i]) if (mq[i].idx == g && mq[i].rdy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_value(input logic [ROB_BIT-1:0] g);
        if (wb_valid && wb_rob_entry == g) return wb_value;
        foreach (mq[i]) if (mq[i].idx == g) return mq[i].val;
        return 32'd0;
    endfunction

    task automatic model_update();
        int   n0;
        bit   flushed;
        ent_t e;
        if (!rdy_in) return;
        exp_commit = 1'b0;
        exp_store  = 1'b0;
        exp_clear  = 1'b0;
        flushed    = 1'b0;
        n0 = mq.size();
        if (n0 > 0 && mq[0].rdy) begin
            e = mq[0];
            exp_commit = 1'b1;
            exp_entry  = e.idx;
            exp_data   = e.val;
            exp_id     = (e.typ == 0) ? e.rd : 5'd0;
            exp_store  = (e.typ == 2);
            if (e.typ == 1 && e.jmp != e.pred) begin
                exp_clear = 1'b1;
                exp_pc    = e.tgt;
                flushed   = 1'b1;
            end
            mq.delete(0);
        end
        if (flushed) begin
            mq.delete();
            m_tail = '0;
        end else if (!m_clr) begin
            if (wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == wb_rob_entry) begin
                        mq[i].rdy = 1'b1;
                        mq[i].val = wb_value;
                        mq[i].jmp = wb_jump;
                        mq[i].tgt = wb_target;
                    end
                end
            end
            if (issue_valid && n0 < ROB_SIZE) begin
                e = '{idx: m_tail, typ: int'(issue_type), rd: issue_rd, pred: issue_pred_jump,
                      rdy: 1'b0, val: 32'd0, jmp: 1'b0, tgt: 32'd0};
                mq.push_back(e);
                m_tail = m_tail + 1'b1;
            end
        end
        m_clr = flushed;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        rdy_in      = 1'b1;
    endtask

    // One clock: check lookups mid-cycle, advance model, check registered outputs.
    task automatic tick();
        #3;
        chk("rob_full", 32'(rob_full), 32'(mq.size() == ROB_SIZE));
        chk("issue_rob_entry", 32'(issue_rob_entry), 32'(m_tail));
        chk("ready1", 32'(ready1), 32'(m_ready(get_rob_entry1)));
        if (m_ready(get_rob_entry1)) chk("value1", value1, m_value(get_rob_entry1));
        chk("ready2", 32'(ready2), 32'(m_ready(get_rob_entry2)));
        if (m_ready(get_rob_entry2)) chk("value2", value2, m_value(get_rob_entry2));
        model_update();
        @(posedge clk_in);
        #1;
        chk("rob_commit", 32'(rob_commit), 32'(exp_commit));
        chk("store_commit", 32'(store_commit), 32'(exp_store));
        chk("rob_clear_up", 32'(rob_clear_up), 32'(exp_clear));
        if (exp_commit) begin
            chk("commit_reg_id", 32'(commit_reg_id), 32'(exp_id));
            chk("commit_reg_data", commit_reg_data, exp_data);
            chk("commit_rob_entry", 32'(commit_rob_entry), 32'(exp_entry));
        end
        if (exp_clear) chk("clear_pc", clear_pc, exp_pc);
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mq.delete();
        m_tail = '0;
        m_clr = 1'b0;
        exp_commit = 1'b0; exp_store = 1'b0; exp_clear = 1'b0;
        exp_id = 5'd0; exp_data = 32'd0; exp_pc = 32'd0; exp_entry = '0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_jump = pred;
    endtask

    task automatic wb(input logic [ROB_BIT-1:0] idx, input logic [31:0] v,
                      input logic j, input logic [31:0] tg);
        wb_valid = 1'b1; wb_rob_entry = idx; wb_value = v; wb_jump = j; wb_target = tg;
    endtask

    typedef struct {
        logic               iv;
        logic [1:0]         ity;
        logic [4:0]         ird;
        logic               ipred;
        logic               wv;
        logic [ROB_BIT-1:0] we;
        logic [31:0]        wval;
        logic               wj;
        logic               e_commit;
        logic [4:0]         e_id;
        logic [31:0]        e_data;
        logic [ROB_BIT-1:0] e_entry;
        logic               e_clear;
        logic [ROB_BIT-1:0] e_tail;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 2'd0, 5'd5, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,    3'd0, 1'b0, 3'd1};
        vt[1] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h1234, 1'b0, 1'b0, 5'd0, 32'h0,    3'd0, 1'b0, 3'd1};
        vt[2] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 1'b1, 5'd5, 32'h1234, 3'd0, 1'b0, 3'd1};
        vt[3] = '{1'b1, 2'd1, 5'd9, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,    3'd0, 1'b0, 3'd2};
        vt[4] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 3'd1, 32'h44,   1'b0, 1'b0, 5'd0, 32'h0,    3'd0, 1'b0, 3'd2};
        vt[5] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 1'b1, 5'd0, 32'h44,   3'd1, 1'b0, 3'd2};

        do_reset();
        chk("reset_full", 32'(rob_full), 32'd0);
        chk("reset_tail", 32'(issue_rob_entry), 32'd0);
        chk("reset_commit", 32'(rob_commit), 32'd0);
        chk("reset_store", 32'(store_commit), 32'd0);
        chk("reset_clear", 32'(rob_clear_up), 32'd0);
        chk("reset_data", commit_reg_data, 32'd0);
        chk("reset_pc", clear_pc, 32'd0);

        // Basic retire plus a correctly predicted branch.
        for (int i = 0; i < 6; i++) begin
            issue_valid = vt[i].iv; issue_type = vt[i].ity; issue_rd = vt[i].ird;
            issue_pred_jump = vt[i].ipred;
            wb_valid = vt[i].wv; wb_rob_entry = vt[i].we; wb_value = vt[i].wval;
            wb_jump = vt[i].wj; wb_target = 32'h0;
            tick();
            chk("vec_commit", 32'(rob_commit), 32'(vt[i].e_commit));
            if (vt[i].e_commit) begin
                chk("vec_id", 32'(commit_reg_id), 32'(vt[i].e_id));
                chk("vec_data", commit_reg_data, vt[i].e_data);
                chk("vec_entry", 32'(commit_rob_entry), 32'(vt[i].e_entry));
            end
            chk("vec_clear", 32'(rob_clear_up), 32'(vt[i].e_clear));
            chk("vec_tail", 32'(issue_rob_entry), 32'(vt[i].e_tail));
        end
        idle();

        // Fill, overflow attempt, then wrap after one retirement.
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0);
            tick();
        end
        chk("full_after_8", 32'(rob_full), 32'd1);
        issue(2'd0, 5'd20, 1'b0);
        tick();
        idle();
        chk("ninth_ignored_tail", 32'(issue_rob_entry), 32'd0);
        chk("ninth_ignored_full", 32'(rob_full), 32'd1);
        wb(3'd0, 32'hA0, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        chk("full_after_commit", 32'(rob_full), 32'd0);
        chk("wrap_index", 32'(issue_rob_entry), 32'd0);
        issue(2'd0, 5'd21, 1'b0);
        tick();
        idle();
        chk("wrap_alloc", 32'(issue_rob_entry), 32'd1);
        chk("wrap_full", 32'(rob_full), 32'd1);

        // Out-of-order completion still retires in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0);
            tick();
        end
        idle();
        wb(3'd2, 32'h22, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        tick();
        chk("no_early_commit", 32'(rob_commit), 32'd0);
        wb(3'd0, 32'h20, 1'b0, 32'd0);
        tick();
        wb(3'd1, 32'h21, 1'b0, 32'd0);
        tick();
        idle();
        chk("ooo_first", 32'(commit_rob_entry), 32'd0);
        chk("ooo_first_pulse", 32'(rob_commit), 32'd1);
        tick();
        chk("ooo_second", 32'(commit_rob_entry), 32'd1);
        tick();
        chk("ooo_third", 32'(commit_rob_entry), 32'd2);
        chk("ooo_third_data", commit_reg_data, 32'h22);
        tick();
        chk("ooo_drained", 32'(rob_commit), 32'd0);

        // Same-cycle lookup bypass.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0);
            tick();
        end
        idle();
        get_rob_entry1 = 3'd3;
        wb(3'd3, 32'hBEEF, 1'b0, 32'd0);
        #1;
        chk("bypass_ready1", 32'(ready1), 32'd1);
        chk("bypass_value1", value1, 32'hBEEF);
        tick();
        idle();

        // Mispredicted branch with younger entries in flight.
        do_reset();
        issue(2'd1, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'(i + 10), 1'b0);
            tick();
        end
        idle();
        wb(3'd0, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        tick();
        chk("mp_clear", 32'(rob_clear_up), 32'd1);
        chk("mp_pc", clear_pc, 32'h100);
        chk("mp_commit", 32'(rob_commit), 32'd1);
        chk("mp_id", 32'(commit_reg_id), 32'd0);
        chk("mp_tail", 32'(issue_rob_entry), 32'd0);
        chk("mp_full", 32'(rob_full), 32'd0);
        issue(2'd0, 5'd7, 1'b0);
        wb(3'd1, 32'h55, 1'b0, 32'd0);
        tick();
        idle();
        chk("mp_discard_issue", 32'(issue_rob_entry), 32'd0);
        chk("mp_clear_once", 32'(rob_clear_up), 32'd0);

        // Store retirement held off by rdy_in low.
        do_reset();
        issue(2'd2, 5'd3, 1'b0);
        tick();
        idle();
        wb(3'd0, 32'h77, 1'b0, 32'd0);
        tick();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_store", 32'(store_commit), 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        chk("store_pulse", 32'(store_commit), 32'd1);
        chk("store_id", 32'(commit_reg_id), 32'd0);
        tick();
        chk("store_pulse_end", 32'(store_commit), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int k;
            rdy_in          = ($urandom % 8) != 0;
            issue_valid     = $urandom % 2;
            issue_type      = 2'($urandom % 3);
            issue_rd        = 5'($urandom);
            issue_pred_jump = $urandom % 2;
            wb_valid        = ($urandom % 3) != 0;
            wb_value        = $urandom;
            wb_target       = $urandom;
            if (mq.size() > 0 && ($urandom % 4) != 0) begin
                k = $urandom_range(mq.size() - 1, 0);
                wb_rob_entry = mq[k].idx;
                wb_jump      = (($urandom % 4) == 0) ? !mq[k].pred : mq[k].pred;
            end else begin
                wb_rob_entry = ROB_BIT'($urandom);
                wb_jump      = $urandom % 2;
            end
            get_rob_entry1 = ROB_BIT'($urandom);
            get_rob_entry2 = ROB_BIT'($urandom);
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer for the out-of-order core.
- Entries are allocated in program order at issue. Results are captured from the CDB writeback. Entries retire in order from the head.
- Retirement drives the register file commit port (rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry) and the global flush (rob_clear_up) on branch mispredict.
- Answers the register file's dependency lookups (get_rob_entry1/2 -> ready1/2, value1/2).

Parameters:
ROB_BIT, 3, entry index width; depth ROB_SIZE = 2**ROB_BIT (8)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  pause when low: no state change
issue_valid  in  1  allocate entry at tail this cycle
issue_type  in  2  0=REG write, 1=BRANCH, 2=STORE
issue_rd  in  5  destination register (REG only)
issue_pred_jump  in  1  predicted taken (BRANCH only)
issue_rob_entry  out  ROB_BIT  current tail index, given to decoder/reg file
rob_full  out  1  count == ROB_SIZE
wb_valid  in  1  CDB broadcast
wb_rob_entry  in  ROB_BIT  producing entry
wb_value  in  32  result
wb_jump  in  1  actual taken (BRANCH)
wb_target  in  32  correct next PC (BRANCH)
get_rob_entry1  in  ROB_BIT  lookup index 1
ready1  out  1  entry 1 result available
value1  out  32  entry 1 result
get_rob_entry2  in  ROB_BIT  lookup index 2
ready2  out  1  entry 2 result available
value2  out  32  entry 2 result
rob_commit  out  1  registered one-cycle commit pulse
commit_reg_id  out  5  rd of committed entry (0 for BRANCH/STORE)
commit_reg_data  out  32  committed value
commit_rob_entry  out  ROB_BIT  committed index
store_commit  out  1  pulse: head STORE retired; LSB may write memory
rob_clear_up  out  1  registered one-cycle flush pulse
clear_pc  out  32  fetch redirect target, valid with rob_clear_up

Behaviour:
- Reset: head = tail = count = 0; all busy/ready bits 0. All outputs 0.
- Priority per cycle: rst_in, then !rdy_in (freeze everything; outputs hold), then flush, then normal operation.
- Issue:
  - Accepted only when issue_valid and count < ROB_SIZE. When full, the request is ignored; the issuer must check rob_full.
  - On accept: entry[tail] <= {busy=1, ready=0, type, rd, pred}; tail wraps modulo ROB_SIZE.
  - rob_full is computed from registered count. A commit in the same cycle does not admit an issue while full.
- Writeback: when wb_valid and entry busy, set ready=1 and store value, jump and target. The ready bit is visible to the commit logic one cycle later.
- Lookup is combinational: readyN = entry.ready | (wb_valid & wb_rob_entry == get_rob_entryN). valueN bypasses wb_value on that same match.
- Commit: at most one per cycle, when count > 0 and entry[head].ready.
  - Next cycle: rob_commit = 1, commit_rob_entry = head.
  - commit_reg_id = rd for REG, 0 otherwise; commit_reg_data = stored value.
  - store_commit = 1 for STORE.
  - head advances with wrap; count decrements.
  - Issue and commit in the same cycle leave count unchanged.
- Mispredict: when the head is BRANCH and ready with jump != pred_jump:
  - The branch retires with rob_commit = 1 and commit_reg_id = 0.
  - Same edge: rob_clear_up = 1, clear_pc = target.
  - head, tail, count and every busy/ready bit reset at that edge.
  - Issue and writeback arriving during the rob_clear_up cycle are discarded.
- A correctly predicted branch retires normally with rob_clear_up = 0.
- All pulses (rob_commit, store_commit, rob_clear_up) are high for exactly one rdy_in-enabled cycle.
- Wrap-around: an entry index is reused only after it commits. Stale writebacks to non-busy entries are ignored.

Decomposition:
- Shared constants (ROB_BIT, the issue_type encodings, ROB_SIZE) go in Const.v.
- Single module. An optional sub-module rob_lookup_port, instantiated twice, isolates the bypass mux for lookup ports 1 and 2.

Test Plan:
- Reset, then issue REG rd=5; writeback entry 0 with value 0x1234 -> two cycles later rob_commit=1, commit_reg_id=5, commit_reg_data=0x1234, commit_rob_entry=0.
- Issue 8 entries -> rob_full=1 and a 9th issue is ignored. Commit entry 0 -> rob_full=0, next issue gets index 0 (wrap).
- Writeback entry 2 before entries 0 and 1 -> no commit until entries 0 and 1 are ready; then commits come out in order 0, 1, 2 on consecutive cycles.
- Lookup get_rob_entry1=3 in the same cycle as a writeback to entry 3 with 0xBEEF -> ready1=1, value1=0xBEEF combinationally.
- BRANCH pred=0, writeback jump=1, target=0x100, with 3 younger entries -> rob_clear_up=1, clear_pc=0x100, commit_reg_id=0; next cycle count=0 and issue_rob_entry equals head.
- STORE at head ready with rdy_in low for 3 cycles -> no pulse while low; store_commit=1 for exactly one enabled cycle after rdy_in rises.
